// File: rtl/uart_rx_ext.sv
// uart_rx_ext: oversampling UART receiver with majority vote, 5..9 data bits,
// optional parity, 1/2 stop bits and parity/framing/break flags.
module uart_rx_ext #(
    parameter int pBAUD_RATE    = 115200,
    parameter int pSYS_CLK_FREQ = 50000000,
    parameter int DATA_BITS     = 8,
    parameter int STOP_BITS     = 1,
    parameter int PARITY        = 0,
    parameter int OVERSAMPLE    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 busy
);
    localparam int DIV_RAW = pSYS_CLK_FREQ / (pBAUD_RATE * OVERSAMPLE);
    localparam int DIV     = DIV_RAW < 1 ? 1 : DIV_RAW;
    localparam int DW      = DIV > 1 ? $clog2(DIV) : 1;
    localparam int SW      = $clog2(OVERSAMPLE);
    localparam int BW      = $clog2(DATA_BITS);
    localparam int M       = OVERSAMPLE / 2;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [SW-1:0] SC_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] SC_A     = SW'(M - 1);
    localparam logic [SW-1:0] SC_B     = SW'(M);
    localparam logic [SW-1:0] SC_V     = SW'(M + 1);
    localparam logic [BW-1:0] BI_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    state_t               state_q, state_d;
    logic [DW-1:0]        div_q;
    logic [1:0]           sync_q;
    logic                 armed_q;
    logic [SW-1:0]        sc_q;
    logic [BW-1:0]        bi_q;
    logic [1:0]           v_q;
    logic [DATA_BITS-1:0] sh_q;
    logic                 par_q, perr_q, ferr_q, one_q;
    logic [DATA_BITS-1:0] dout_q;
    logic                 dv_q, pe_q, fe_q, bd_q;
    logic                 tick, rx_s, vote, vote_t, bit_end, last_stop, brk;

    assign tick      = div_q == DIV_LAST;
    assign rx_s      = sync_q[1];
    assign vote      = (v_q[0] & v_q[1]) | (v_q[0] & rx_s) | (v_q[1] & rx_s);
    assign vote_t    = tick && sc_q == SC_V;
    assign bit_end   = tick && sc_q == SC_LAST;
    // Leave STOP at the vote, not the bit end, to resync on back-to-back frames
    assign last_stop = state_q == S_STOP && vote_t && (STOP_BITS == 1 || bi_q == BW'(1));
    assign brk       = !(one_q | vote);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (tick && armed_q && !rx_s) state_d = S_START;
            S_START: state_d = (vote_t && vote) ? S_IDLE : bit_end ? S_DATA : S_START;
            S_DATA:  if (bit_end && bi_q == BI_LAST) state_d = PARITY != 0 ? S_PAR : S_STOP;
            S_PAR:   if (bit_end) state_d = S_STOP;
            S_STOP:  if (last_stop) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = state_q != S_IDLE;
        data_out   = dout_q;
        data_valid = dv_q;
        parity_err = pe_q;
        frame_err  = fe_q;
        break_det  = bd_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            sync_q  <= 2'b11;
            armed_q <= 1'b0;
            sc_q    <= '0;
            bi_q    <= '0;
            v_q     <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            one_q   <= 1'b0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            bd_q    <= 1'b0;
        end else begin
            div_q   <= tick ? '0 : div_q + DW'(1);
            sync_q  <= {sync_q[0], rx};
            dv_q    <= last_stop;
            armed_q <= (last_stop && brk) ? 1'b0 : (tick && rx_s) ? 1'b1 : armed_q;
            if (last_stop) begin
                dout_q <= sh_q;
                pe_q   <= perr_q;
                fe_q   <= ferr_q | !vote;
                bd_q   <= brk;
            end
            if (tick) begin
                sc_q <= (state_q == S_IDLE || sc_q == SC_LAST) ? '0 : sc_q + SW'(1);
                bi_q <= (state_d != state_q) ? '0 : (sc_q == SC_LAST) ? bi_q + BW'(1) : bi_q;
                if (sc_q == SC_A) v_q[0] <= rx_s;
                if (sc_q == SC_B) v_q[1] <= rx_s;
                if (state_q == S_IDLE) begin
                    par_q  <= 1'b0;
                    perr_q <= 1'b0;
                    ferr_q <= 1'b0;
                    one_q  <= 1'b0;
                end
                if (sc_q == SC_V) begin
                    if (state_q == S_DATA) begin
                        sh_q  <= {vote, sh_q[DATA_BITS-1:1]};
                        par_q <= par_q ^ vote;
                    end
                    if (state_q == S_PAR) perr_q <= (PARITY == 1) ? ~(par_q ^ vote) : (par_q ^ vote);
                    if (state_q == S_STOP && !vote) ferr_q <= 1'b1;
                    if (state_q == S_DATA || state_q == S_PAR || state_q == S_STOP) one_q <= one_q | vote;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_ext.sv
// tb_uart_rx_ext: directed frames into an 8N1 and an 8E1 receiver, checked every
// cycle against a frame-level model plus a few literal expectations.
`timescale 1ns/1ps
module tb_uart_rx_ext;
    localparam int SYS = 18432000, BAUD = 115200, OVS = 16, BT = 160;

    typedef struct packed {
        logic [7:0] d;
        logic       pe, fe, br;
    } exp_t;

    logic       clk = 1'b0, rst = 1'b1;
    logic       rx0, rx1;
    logic [7:0] d0, d1;
    logic       dv0, dv1, pe0, pe1, fe0, fe1, br0, br1, bz0, bz1;
    exp_t       q0[$], q1[$];
    exp_t       cur [2];
    int         nvec = 0, nerr = 0, busy_cyc = 0;

    uart_rx_ext #(.pBAUD_RATE(BAUD), .pSYS_CLK_FREQ(SYS), .DATA_BITS(8), .STOP_BITS(1),
                  .PARITY(0), .OVERSAMPLE(OVS)) u_n1 (
        .clk(clk), .rst(rst), .rx(rx0), .data_out(d0), .data_valid(dv0),
        .parity_err(pe0), .frame_err(fe0), .break_det(br0), .busy(bz0));

    uart_rx_ext #(.pBAUD_RATE(BAUD), .pSYS_CLK_FREQ(SYS), .DATA_BITS(8), .STOP_BITS(1),
                  .PARITY(2), .OVERSAMPLE(OVS)) u_e1 (
        .clk(clk), .rst(rst), .rx(rx1), .data_out(d1), .data_valid(dv1),
        .parity_err(pe1), .frame_err(fe1), .break_det(br1), .busy(bz1));

    always #5 clk = ~clk;

    // Frame-level model: bits[0] start, [8:1] data, [9] parity when present, then stop bits
    function automatic exp_t model(input logic [15:0] bits, input int n, input bit par);
        exp_t e;
        int   first_stop;
        e.d        = bits[8:1];
        e.pe       = par && ((^bits[8:1]) ^ bits[9]) != 1'b0;
        first_stop = par ? 10 : 9;
        e.fe       = 1'b0;
        for (int i = first_stop; i < n; i++) if (!bits[i]) e.fe = 1'b1;
        e.br = 1'b1;
        for (int i = 1; i < n; i++) if (bits[i]) e.br = 1'b0;
        return e;
    endfunction

    task automatic chk(input int i, input logic dv, input logic [7:0] d,
                       input logic pe, input logic fe, input logic br, input logic bz);
        if (rst) begin
            cur[i] = '0;
            nvec++;
            if ({dv, d, pe, fe, br, bz} !== 13'b0) begin
                nerr++;
                $display("FAIL reset%0d: got dv=%b d=%h pe=%b fe=%b br=%b busy=%b, want all 0",
                         i, dv, d, pe, fe, br, bz);
            end
            return;
        end
        if (dv) begin
            if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                nvec++;
                nerr++;
                $display("FAIL strobe%0d: unexpected data_valid with d=%h at %0t", i, d, $time);
                return;
            end
            if (i == 0) cur[0] = q0.pop_front();
            else        cur[1] = q1.pop_front();
        end
        nvec++;
        if ({d, pe, fe, br} !== {cur[i].d, cur[i].pe, cur[i].fe, cur[i].br}) begin
            nerr++;
            $display("FAIL out%0d: got d=%h pe=%b fe=%b br=%b, want d=%h pe=%b fe=%b br=%b at %0t",
                     i, d, pe, fe, br, cur[i].d, cur[i].pe, cur[i].fe, cur[i].br, $time);
        end
    endtask

    always @(negedge clk) begin
        chk(0, dv0, d0, pe0, fe0, br0, bz0);
        chk(1, dv1, d1, pe1, fe1, br1, bz1);
        if (bz0) busy_cyc++;
    end

    task automatic lit(input string name, input logic [15:0] act, input logic [15:0] want);
        nvec++;
        if (act !== want) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic drive(input int l, input logic v);
        if (l == 0) rx0 = v;
        else        rx1 = v;
    endtask

    task automatic send(input int l, input logic [7:0] data, input logic pbit, input logic stop);
        logic [15:0] b;
        int          n;
        b      = '1;
        b[0]   = 1'b0;
        b[8:1] = data;
        if (l == 1) begin b[9] = pbit; b[10] = stop; n = 11; end
        else        begin b[9] = stop; n = 10; end
        if (l == 0) q0.push_back(model(b, n, 1'b0));
        else        q1.push_back(model(b, n, 1'b1));
        for (int i = 0; i < n; i++) begin
            drive(l, b[i]);
            repeat (BT) @(posedge clk);
        end
        drive(l, 1'b1);
    endtask

    // The pending strobe must have drained by the end of the wait
    task automatic settle(input int l, input int nbits);
        int left;
        repeat (nbits * BT) @(posedge clk);
        left = (l == 0) ? q0.size() : q1.size();
        nvec++;
        if (left != 0) begin
            nerr++;
            $display("FAIL missing_strobe%0d: %0d expected frames still pending, want 0", l, left);
        end
    endtask

    initial begin
        int b0;
        rx0 = 1'b1;
        rx1 = 1'b1;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);

        b0 = busy_cyc;
        send(0, 8'hA5, 1'b0, 1'b1);
        settle(0, 2);
        lit("a5_data", {8'h0, d0}, 16'h00A5);
        lit("a5_flags", {13'h0, pe0, fe0, br0}, 16'h0000);
        lit("a5_busy_len_ok", {15'h0, (busy_cyc - b0) >= 1480 && (busy_cyc - b0) <= 1600}, 16'h0001);

        send(1, 8'h03, 1'b1, 1'b1);
        settle(1, 2);
        lit("even_bad_pe", {15'h0, pe1}, 16'h0001);
        send(1, 8'h03, 1'b0, 1'b1);
        settle(1, 2);
        lit("even_good_pe", {15'h0, pe1}, 16'h0000);

        send(0, 8'h41, 1'b0, 1'b0);
        settle(0, 3);
        lit("stop_low_data", {8'h0, d0}, 16'h0041);
        lit("stop_low_fe_br", {14'h0, fe0, br0}, 16'h0002);

        drive(0, 1'b0);
        repeat (40) @(posedge clk);
        lit("glitch_busy_hi", {15'h0, bz0}, 16'h0001);
        repeat (8) @(posedge clk);
        drive(0, 1'b1);
        repeat (2 * BT) @(posedge clk);
        lit("glitch_busy_lo", {15'h0, bz0}, 16'h0000);
        lit("glitch_data_held", {8'h0, d0}, 16'h0041);

        q0.push_back(model(16'h0000, 10, 1'b0));
        drive(0, 1'b0);
        repeat (11 * BT + BT / 2) @(posedge clk);
        lit("break_not_rearmed", {15'h0, bz0}, 16'h0000);
        lit("break_flags", {13'h0, pe0, fe0, br0}, 16'h0003);
        lit("break_data", {8'h0, d0}, 16'h0000);
        repeat (BT / 2) @(posedge clk);
        drive(0, 1'b1);
        settle(0, 3);

        send(0, 8'h55, 1'b0, 1'b1);
        send(0, 8'hAA, 1'b0, 1'b1);
        drive(0, 1'b0);
        repeat (BT) @(posedge clk);
        drive(0, 1'b1);
        repeat (BT) @(posedge clk);
        drive(0, 1'b0);
        repeat (BT + BT / 2) @(posedge clk);
        lit("b2b_both_done", {8'h0, d0}, 16'h00AA);
        lit("third_busy", {15'h0, bz0}, 16'h0001);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        drive(0, 1'b1);
        repeat (3) @(posedge clk);
        rst = 1'b0;
        settle(0, 12);
        lit("post_rst_data", {8'h0, d0}, 16'h0000);
        lit("post_rst_busy", {15'h0, bz0}, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_rx_ext.md
Name: uart_rx_ext

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver. Adds an internal baud/oversample tick generator, a 2-flop input synchroniser, and majority-vote sampling. Supports 5–9 data bits, optional odd/even parity, 1 or 2 stop bits, parity/framing/break error flags and a one-cycle data_valid strobe. Sits between the pad-level rx line and the byte consumer (FIFO or register block) in the serial subsystem.

Parameters:
pBAUD_RATE, 115200, line baud rate in bit/s
pSYS_CLK_FREQ, 50000000, clk frequency in Hz
DATA_BITS, 8, data bits per frame; legal 5..9
STOP_BITS, 1, stop bits per frame; legal 1 or 2
PARITY, 0, 0 = none, 1 = odd, 2 = even
OVERSAMPLE, 16, sample ticks per bit; even, >= 8

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
rx  input  1  serial line, idle high, asynchronous to clk
data_out  output  DATA_BITS  last received word, LSB = first data bit
data_valid  output  1  one-clk pulse when data_out and the flags update
parity_err  output  1  parity mismatch in last frame (always 0 when PARITY = 0)
frame_err  output  1  at least one stop bit sampled low in last frame
break_det  output  1  last frame was all-zero, including parity and stop bits
busy  output  1  high while state is not IDLE

Behaviour:
- Reset and clocking: one clock domain (clk). rst is asynchronous and active-high.
- Reset values:
  - data_out = 0; data_valid, parity_err, frame_err, break_det and busy = 0.
  - state = IDLE; all counters = 0; both synchroniser flops = 1; armed = 0.
- Tick generator:
  - DIV = pSYS_CLK_FREQ / (pBAUD_RATE * OVERSAMPLE), integer floor, clamped to a minimum of 1.
  - tick is high for 1 clk every DIV clks, free-running from reset. Behaviour is clk-synchronous only.
- Synchroniser: rx passes through two flops to give rx_s. All logic uses rx_s only.
- Arming:
  - armed sets on the first tick where rx_s = 1.
  - Start detection requires armed = 1, so a line held low through reset does not start a frame.
- Sampling:
  - Within a bit, the tick counter sc runs 0..OVERSAMPLE-1.
  - The bit value is the majority of rx_s at sc = M-1, M and M+1, where M = OVERSAMPLE/2. The vote resolves at sc = M+1.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a tick with armed and rx_s = 0, go to START with sc = 0.
  - START: if the vote = 1, it is a false start; return to IDLE with no strobe and no flag change. Otherwise, at sc = OVERSAMPLE-1, go to DATA with bit index = 0.
  - DATA: each voted bit shifts in LSB first. After bit DATA_BITS-1 (at sc = OVERSAMPLE-1), go to PARITY if PARITY != 0, else go to STOP.
  - PARITY: compare the voted bit against the running XOR of the data bits.
    - odd: XOR of data bits ^ parity bit must be 1.
    - even: XOR of data bits ^ parity bit must be 0.
  - STOP: each stop bit is voted. A 0 on any stop bit sets the pending frame error.
    - At the vote of the last stop bit (sc = M+1, not the end of the bit), go to IDLE. This gives half-bit resync margin for back-to-back frames.
- Output update:
  - In the clk after the last stop-bit vote resolves, data_out, parity_err, frame_err and break_det load together and data_valid = 1 for exactly 1 clk.
  - The update happens regardless of errors.
  - Flags hold until the next data_valid.
- break_det = 1 only when all data bits, the parity bit (if present) and all stop bits voted 0. frame_err is also 1 in that case.
- After a break, the armed flag is cleared. The next start needs rx_s to return high first.
- busy = 1 from the IDLE→START transition until re-entry to IDLE. It also drops on a false start.
- Reset mid-frame: the frame is discarded, with no strobe and outputs at their reset values.
- Width rules:
  - sc is clog2(OVERSAMPLE) bits.
  - Bit index is clog2(DATA_BITS) bits.
  - Tick divider is clog2(DIV) bits, with a minimum of 1 bit.
  - No truncation on the shift register: it is DATA_BITS wide.

Test Plan:
Bench parameters: pSYS_CLK_FREQ = 18432000, pBAUD_RATE = 115200, OVERSAMPLE = 16, giving DIV = 10 and 160 clk/bit.
- 8N1, send 0xA5 -> data_valid pulses once, data_out = 0xA5, all flags 0, busy high for ~9.5 bit times.
- PARITY = 2 (even), send 0x03 with parity bit 1 -> data_out = 0x03, parity_err = 1; resend with parity bit 0 -> parity_err = 0.
- Stop bit driven low, send 0x41 -> data_out = 0x41, frame_err = 1, break_det = 0, data_valid pulses once.
- rx low for 48 clk then high (a glitch shorter than half a bit) -> no data_valid, returns to IDLE, busy drops, flags unchanged.
- rx held low for 12 bit times, then high -> data_valid with data_out = 0, frame_err = 1, break_det = 1; no second frame until rx goes high.
- Two back-to-back 0x55 / 0xAA frames, then rst asserted mid-way through a third frame's data bits -> two correct strobes; after reset all outputs are 0 and there is no strobe for the third frame.
